// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the four requesters, the arbiter and the serial sender.
//
// Handshakes (both four-phase, level based):
//   requester i : raises req_in[i] with its byte on data_in[8i+7:8i]; the
//                 arbiter answers with ack_out[i]; the requester drops
//                 req_in[i], then the arbiter drops ack_out[i].
//   sender      : arbiter raises XMT_REQ with XMT_DATA stable; the sender
//                 raises XMT_ACK when done; the arbiter drops XMT_REQ; the
//                 sender drops XMT_ACK.
// The master modport is the arbiter's view, the slave modport the environment's.
interface uart_tx_arbiter_if;
  logic [3:0]  req_in;
  logic [31:0] data_in;
  logic [3:0]  ack_out;
  logic        XMT_REQ;
  logic [7:0]  XMT_DATA;
  logic        XMT_ACK;

  modport master (
    input  req_in, data_in, XMT_ACK,
    output ack_out, XMT_REQ, XMT_DATA
  );

  modport slave (
    output req_in, data_in, XMT_ACK,
    input  ack_out, XMT_REQ, XMT_DATA
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one serial sender.
// A winning requester's byte is captured on grant and held on XMT_DATA
// until the sender has finished; the requester is then acknowledged.
// Optional feature macro: XMT_ARB_TIMEOUT_EN -- aborts a transfer whose
// sender does not complete within TIMEOUT_CYCLES and flags timeout_err.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     clr_n,
  uart_tx_arbiter_if.master        bus,
  output logic                     busy,
  output logic [1:0]               grant_id,
  output logic                     timeout_err,
  output logic [2:0]               fsm_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND    = 3'd1;
  localparam logic [2:0] RELEASE = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] ABORT   = 3'd4;

  // The timeout counter needs at least one cycle of SEND before expiry.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  logic [2:0] state;
  logic [1:0] last_grant;
  logic [7:0] data_q;
  logic [1:0] pick;
  logic       pick_valid;
  logic       expired;

  // Round-robin search starting just after the previous grantee; the
  // previous grantee itself is considered last so it cannot starve others.
  always_comb begin
    logic [1:0] cand;
    pick       = 2'd0;
    pick_valid = 1'b0;
    cand       = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (bus.req_in[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

`ifdef XMT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  assign expired = ((state == SEND) || (state == RELEASE)) &&
                   (to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on the sender; restart on every new grant.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      to_cnt <= '0;
    end else if ((state == IDLE) && pick_valid) begin
      to_cnt <= '0;
    end else if ((state == SEND) || (state == RELEASE)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      timeout_err <= 1'b0;
    end else if (expired && !((state == SEND) && bus.XMT_ACK)) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main FSM: grant, drive the sender handshake, acknowledge the requester.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      data_q     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id   <= pick;
            last_grant <= pick;
            data_q     <= bus.data_in[{pick, 3'b000} +: 8];
            state      <= SEND;
          end
        end
        SEND: begin
          // A completing sender wins over a simultaneous expiry.
          if (bus.XMT_ACK) begin
            state <= RELEASE;
          end else if (expired) begin
            state <= DONE;
          end
        end
        RELEASE: begin
          if (!bus.XMT_ACK || expired) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.req_in[grant_id]) begin
            state <= IDLE;
          end
        end
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // removes XMT_REQ and ack_out without waiting for a clock edge.
  always_comb begin
    bus.ack_out  = 4'b0000;
    if (state == DONE) begin
      bus.ack_out[grant_id] = 1'b1;
    end
    bus.XMT_REQ  = (state == SEND);
    bus.XMT_DATA = data_q;
    busy         = (state != IDLE);
    fsm_state    = state;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a sender model answers XMT_REQ after
// a chosen latency, and a scoreboard queue holds the bytes that must show
// up on XMT_DATA in order.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_err;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .bus         (bus.master),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sender model for one transfer. mode 1 rewrites the grantee's data_in
  // during SEND; mode 2 drops the grantee's request during SEND.
  task automatic do_transfer(input logic [1:0] gid, input int lat, input int mode,
                             input bit release_req, input bit rearm);
    logic [7:0] exp_b;
    bit seen;
    exp_b = exp_q.pop_front();
    seen  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.XMT_REQ) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_rise", 32'(seen), 32'd1);
    if (!seen) return;
    check("grant_id", 32'(grant_id), 32'(gid));
    check("xmt_data", 32'(bus.XMT_DATA), 32'(exp_b));
    check("busy_send", 32'(busy), 32'd1);
    if (mode == 1) bus.data_in[8*gid +: 8] = 8'hFF;
    if (mode == 2) bus.req_in[gid] = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      check("req_hold", 32'(bus.XMT_REQ), 32'd1);
      check("data_hold", 32'(bus.XMT_DATA), 32'(exp_b));
    end
    bus.XMT_ACK = 1'b1;
    @(negedge clk);
    check("req_fall", 32'(bus.XMT_REQ), 32'd0);
    check("data_release", 32'(bus.XMT_DATA), 32'(exp_b));
    repeat (2) @(negedge clk);
    check("ack_in_release", 32'(bus.ack_out), 32'd0);
    check("data_release2", 32'(bus.XMT_DATA), 32'(exp_b));
    bus.XMT_ACK = 1'b0;
    @(negedge clk);
    check("ack_done", 32'(bus.ack_out), 32'd1 << gid);
    if (release_req) begin
      bus.req_in[gid] = 1'b0;
      @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("ack_idle", 32'(bus.ack_out), 32'd0);
      if (rearm) bus.req_in[gid] = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    int cnt;
    clr_n       = 1'b0;
    bus.req_in  = 4'b0000;
    bus.data_in = 32'h0;
    bus.XMT_ACK = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_xmt_req", 32'(bus.XMT_REQ), 32'd0);
    check("rst_xmt_data", 32'(bus.XMT_DATA), 32'd0);
    check("rst_ack", 32'(bus.ack_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // XMT_ACK in IDLE is ignored
    bus.XMT_ACK = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_state", 32'(fsm_state), 32'd0);
    bus.XMT_ACK = 1'b0;
    @(negedge clk);

    // single requester, slow sender
    bus.data_in = 32'h0000_005A;
    exp_q.push_back(8'h5A);
    bus.req_in  = 4'b0001;
    do_transfer(2'd0, 100, 0, 1'b1, 1'b0);

    // all four at once after reset: 0,1,2,3 then back to 0
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    bus.data_in = 32'h4433_2211;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h11);
    bus.req_in = 4'b1111;
    for (int i = 0; i < 4; i++) do_transfer(2'(i), 3, 0, 1'b1, 1'b1);
    do_transfer(2'd0, 3, 0, 1'b1, 1'b0);
    bus.req_in = 4'b0000;
    @(negedge clk);
    check("rr_end_busy", 32'(busy), 32'd0);

    // data_in change after capture is ignored
    bus.data_in = 32'h00A5_0000;
    exp_q.push_back(8'hA5);
    bus.req_in  = 4'b0100;
    do_transfer(2'd2, 5, 1, 1'b1, 1'b0);

    // request dropped after grant still completes and is acknowledged
    bus.data_in = 32'hC300_0000;
    exp_q.push_back(8'hC3);
    bus.req_in  = 4'b1000;
    do_transfer(2'd3, 3, 2, 1'b1, 1'b0);

    // asynchronous reset during SEND
    bus.data_in = 32'h0000_3C00;
    bus.req_in  = 4'b0010;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.XMT_REQ) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_req_rise", 32'(seen), 32'd1);
    check("rst_mid_grant_before", 32'(grant_id), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("rst_mid_xmt_req", 32'(bus.XMT_REQ), 32'd0);
    check("rst_mid_grant", 32'(grant_id), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    bus.req_in = 4'b0000;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check("rst_mid_no_resume", 32'(busy), 32'd0);

    // first grant after reset goes to requester 0; requester 1 then withdraws
    bus.data_in = 32'h0000_4E6B;
    exp_q.push_back(8'h6B);
    bus.req_in  = 4'b0011;
    do_transfer(2'd0, 4, 0, 1'b0, 1'b0);
    bus.req_in = 4'b0000;
    @(negedge clk);
    check("skip_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("skip_no_grant", 32'(busy), 32'd0);
    check("skip_state", 32'(fsm_state), 32'd0);

`ifdef XMT_ARB_TIMEOUT_EN
    // sender never answers: abort after 16 cycles in SEND
    bus.data_in = 32'h0000_0077;
    bus.req_in  = 4'b0001;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.XMT_REQ) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_req_rise", 32'(seen), 32'd1);
    cnt = 0;
    while (bus.XMT_REQ && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("to_send_len", 32'(cnt), 32'd16);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_ack", 32'(bus.ack_out), 32'd1);
    bus.req_in = 4'b0000;
    @(negedge clk);
    check("to_busy", 32'(busy), 32'd0);
    bus.data_in = 32'h0000_0078;
    exp_q.push_back(8'h78);
    bus.req_in  = 4'b0001;
    do_transfer(2'd0, 2, 0, 1'b1, 1'b0);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4096, maximum cycles spent waiting on the sender in SEND or RELEASE before abort (used only with XMT_ARB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_in  input  4  per-requester transmit request, four-phase handshake.
REQ-005 Port: data_in  input  32  requester i byte on bits [8i+7:8i].
REQ-006 Port: ack_out  output  4  per-requester completion acknowledge, one-hot or zero.
REQ-007 Port: XMT_REQ  output  1  request to the serial sender.
REQ-008 Port: XMT_DATA  output  8  byte presented to the serial sender.
REQ-009 Port: XMT_ACK  input  1  sender completion acknowledge.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: grant_id  output  2  index of the current or most recent grantee.
REQ-012 Port: timeout_err  output  1  sticky sender-timeout flag.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, SEND, RELEASE, DONE, and a reserved ABORT that is unused and maps to IDLE; any illegal encoding SHALL return to IDLE on the next edge.
REQ-014 IDLE: when any req_in bit is high, the grantee SHALL be chosen round-robin, searching from last_grant+1 modulo 4, and on the same edge grant_id, last_grant, and a data register loaded from that requester's byte SHALL update and the FSM SHALL enter SEND.
REQ-015 XMT_REQ SHALL be high exactly while in SEND, rising one cycle after the winning req_in is sampled.
REQ-016 XMT_DATA SHALL come from the data register, SHALL be stable from SEND entry through RELEASE exit, and SHALL ignore data_in changes after capture.
REQ-017 SEND: XMT_ACK high SHALL move the FSM to RELEASE.
REQ-018 RELEASE: XMT_REQ is low; XMT_ACK low SHALL move the FSM to DONE.
REQ-019 DONE: ack_out[grant_id] SHALL be high, and when req_in[grant_id] is low the FSM SHALL go to IDLE.
REQ-020 In DONE, ack_out SHALL be asserted for at least one cycle even if the request is already low.
REQ-021 A requester that deasserts req_in before being granted SHALL be skipped.
REQ-022 A requester that deasserts req_in after being granted SHALL not abort its transfer.
REQ-023 XMT_ACK SHALL be ignored in IDLE and DONE.
REQ-024 A grantee that holds req_in high after completion SHALL not be regranted while any other requester is pending, so that no requester starves.
REQ-025 When all four requests arrive in the same cycle from reset, grants SHALL be issued in the order 0, 1, 2, 3.

Reset
REQ-026 While clr_n is low, the following SHALL hold: state IDLE, XMT_REQ=0, XMT_DATA=0, ack_out=0, busy=0, grant_id=0, last_grant=3, timeout_err=0, timeout counter=0.
REQ-027 Reset assertion mid-transfer SHALL drop XMT_REQ and ack_out immediately, without waiting for a clock edge.
REQ-028 After reset deassertion, the first grant SHALL follow REQ-014 with no pending transfer resumed.

Configuration
REQ-029 Macro XMT_ARB_TIMEOUT_EN: when defined, a counter SHALL clear on entry to SEND and count each cycle in SEND or RELEASE.
REQ-030 With XMT_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL drop XMT_REQ, set timeout_err (sticky until reset), and enter DONE so the grantee is still acknowledged.
REQ-031 With XMT_ARB_TIMEOUT_EN undefined, there SHALL be no counter, timeout_err SHALL be tied 0, and SEND and RELEASE SHALL wait indefinitely.

Verification
REQ-032 Test: req_in=0001, data byte 0x5A, XMT_ACK modelled 100 cycles after XMT_REQ rises and dropped 2 cycles after XMT_REQ falls -> XMT_DATA=0x5A throughout, ack_out=0001 after XMT_ACK falls, busy low after req drop.
REQ-033 Test: req_in=1111 held, bytes 0x11/0x22/0x33/0x44 -> XMT_DATA sequence 0x11, 0x22, 0x33, 0x44, then 0x11 again.
REQ-034 Test: requester 2 changes data_in from 0xA5 to 0xFF during SEND -> XMT_DATA remains 0xA5.
REQ-035 Test: clr_n pulsed low during SEND -> XMT_REQ=0 asynchronously, grant_id=0, and the next grant goes to requester 0 with req_in=0001.
REQ-036 Test: XMT_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, XMT_ACK held 0 -> XMT_REQ drops after 16 cycles in SEND, timeout_err=1, ack_out asserted; timeout_err still 1 after the next good transfer.
